// File: rtl/uart_pkg.sv
// Shared types and constants for the UART responder.
// Optional macro UART_PARITY_EN adds an even-parity bit and the matching
// TX_PARITY / RX_PARITY states.
package uart_pkg;

  localparam int UART_BITS            = 8;
  localparam int CLKS_PER_BIT_DEFAULT = 868;

  typedef enum logic [1:0] {
    REQ_IDLE,
    REQ_RX_WAIT,
    REQ_TX_BUSY
  } req_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef UART_PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef UART_PARITY_EN
    RX_PARITY,
`endif
    RX_STOP
  } rx_state_t;

endpackage

// File: rtl/uart_responder_if.sv
// Request/response handshake between the memory proxy (master) and the
// UART responder (slave).
interface uart_responder_if;
  import uart_pkg::*;

  logic                 ready;
  logic                 t_valid;
  logic [UART_BITS-1:0] t_data;
  logic                 r_valid;
  logic [UART_BITS-1:0] r_data;
  logic                 tx_done;
  logic                 rx_done;

  modport master (
    input  ready, r_data, tx_done, rx_done,
    output t_valid, t_data, r_valid
  );

  modport slave (
    output ready, r_data, tx_done, rx_done,
    input  t_valid, t_data, r_valid
  );
endinterface

// File: rtl/uart_rx_fifo.sv
// Circular receive FIFO with combinational head and sticky overrun flag.
// Full/empty use one extra pointer bit. A write while full is accepted
// only if a pop frees a slot in the same cycle; otherwise it is dropped.
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int FIFO_AW = 4
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 wr_en,
  input  logic [UART_BITS-1:0] wr_data,
  input  logic                 rd_en,
  output logic [UART_BITS-1:0] rd_data,
  output logic                 empty,
  output logic                 full,
  output logic                 overrun
);
  localparam int DEPTH = 2 ** FIFO_AW;

  logic [UART_BITS-1:0] mem [DEPTH];
  logic [FIFO_AW:0]     wptr, rptr;
  logic                 do_wr, do_rd;

  assign empty   = (wptr == rptr);
  assign full    = (wptr[FIFO_AW] != rptr[FIFO_AW]) &&
                   (wptr[FIFO_AW-1:0] == rptr[FIFO_AW-1:0]);
  assign do_rd   = rd_en && !empty;
  assign do_wr   = wr_en && (!full || do_rd);
  assign rd_data = mem[rptr[FIFO_AW-1:0]];

  // Storage array, written at the tail
  always_ff @(posedge clk) begin
    if (do_wr) mem[wptr[FIFO_AW-1:0]] <= wr_data;
  end

  // Pointers and sticky overrun
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      wptr    <= '0;
      rptr    <= '0;
      overrun <= 1'b0;
    end else begin
      if (do_wr) wptr <= wptr + 1'b1;
      if (do_rd) rptr <= rptr + 1'b1;
      if (wr_en && !do_wr) overrun <= 1'b1;
    end
  end
endmodule

// File: rtl/uart_responder.sv
// UART responder: serialises request bytes on txd, deserialises rxd into
// a FIFO and hands bytes back on request. Optional macro UART_PARITY_EN
// switches both directions from 8N1 to 8E1.
//
// state        | meaning
// REQ_IDLE     | ready high, accepting a transmit or receive request
// REQ_RX_WAIT  | receive request pending on an empty FIFO
// REQ_TX_BUSY  | frame being transmitted, tx_done follows the stop bit
// TX_START     | driving start bit
// TX_DATA      | driving data bits, LSB first
// TX_PARITY    | driving even parity (UART_PARITY_EN only)
// TX_STOP      | driving stop bit
// RX_START     | waiting for start-bit midpoint to reject glitches
// RX_DATA      | sampling data bits at bit centres
// RX_PARITY    | sampling parity (UART_PARITY_EN only)
// RX_STOP      | sampling stop bit, write FIFO if high
module uart_responder
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
  parameter int FIFO_AW      = 4
) (
  input  logic            clk,
  input  logic            rstn,
  uart_responder_if.slave bus,
  output logic            txd,
  input  logic            rxd,
  output logic            rx_overrun
);
  localparam int                CNT_W    = $clog2(CLKS_PER_BIT);
  localparam int                IDX_W    = $clog2(UART_BITS);
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0]  CNT_HALF = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [IDX_W-1:0]  IDX_LAST = IDX_W'(UART_BITS - 1);

  req_state_t           req_state, req_next;
  logic                 accept_tx, accept_rx, deliver, ready_d;
  logic [UART_BITS-1:0] deliver_data;

  tx_state_t            tx_state, tx_next;
  logic [CNT_W-1:0]     tx_cnt;
  logic [IDX_W-1:0]     tx_idx;
  logic [UART_BITS-1:0] tx_byte;
  logic                 tx_tc, tx_finish;

  rx_state_t            rx_state, rx_next;
  logic [CNT_W-1:0]     rx_cnt;
  logic [IDX_W-1:0]     rx_idx;
  logic [UART_BITS-1:0] rx_shift;
  logic                 rx_tc, rx_fall, rx_wr;
  logic                 rxd_s1, rxd_s2, rxd_s3;
`ifdef UART_PARITY_EN
  logic                 rx_par_err;
`endif

  logic                 fifo_wr, fifo_pop, fifo_empty;
  logic [UART_BITS-1:0] fifo_rd_data;

  // Transmit takes priority when both requests arrive together
  assign accept_tx = bus.ready && bus.t_valid;
  assign accept_rx = bus.ready && bus.r_valid && !bus.t_valid;

  // Request state and registered handshake outputs
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      req_state   <= REQ_IDLE;
      bus.ready   <= 1'b0;
      bus.tx_done <= 1'b0;
      bus.rx_done <= 1'b0;
      bus.r_data  <= '0;
    end else begin
      req_state   <= req_next;
      bus.ready   <= ready_d;
      bus.tx_done <= tx_finish;
      bus.rx_done <= deliver;
      if (deliver) bus.r_data <= deliver_data;
    end
  end

  // Request next-state
  always_comb begin
    req_next = req_state;
    case (req_state)
      REQ_IDLE: begin
        if (accept_tx)                     req_next = REQ_TX_BUSY;
        else if (accept_rx && fifo_empty)  req_next = REQ_RX_WAIT;
      end
      REQ_RX_WAIT: if (deliver)   req_next = REQ_IDLE;
      REQ_TX_BUSY: if (tx_finish) req_next = REQ_IDLE;
      default:                    req_next = REQ_IDLE;
    endcase
  end

  // Request outputs: pop/deliver, and bypass the FIFO for a waiting reader
  always_comb begin
    fifo_pop     = 1'b0;
    deliver      = 1'b0;
    deliver_data = fifo_rd_data;
    fifo_wr      = rx_wr;
    if (req_state == REQ_IDLE && accept_rx && !fifo_empty) fifo_pop = 1'b1;
    if (req_state == REQ_RX_WAIT) begin
      if (!fifo_empty) begin
        fifo_pop = 1'b1;
      end else if (rx_wr) begin
        deliver      = 1'b1;
        deliver_data = rx_shift;
        fifo_wr      = 1'b0;
      end
    end
    if (fifo_pop) deliver = 1'b1;
    ready_d = !deliver &&
              ((req_state == REQ_IDLE && !accept_tx && !(accept_rx && fifo_empty)) ||
               (req_state == REQ_TX_BUSY && tx_finish));
  end

  assign tx_tc     = (tx_cnt == '0);
  assign tx_finish = (tx_state == TX_STOP) && tx_tc;

  // TX state, bit down-counter, bit index and byte latch
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tx_state <= TX_IDLE;
      tx_cnt   <= CNT_FULL;
      tx_idx   <= '0;
      tx_byte  <= '0;
    end else begin
      tx_state <= tx_next;
      if (tx_state == TX_IDLE || tx_tc) tx_cnt <= CNT_FULL;
      else                              tx_cnt <= tx_cnt - 1'b1;
      if (tx_state != TX_DATA) tx_idx <= '0;
      else if (tx_tc)          tx_idx <= tx_idx + 1'b1;
      if (accept_tx) tx_byte <= bus.t_data;
    end
  end

  // TX next-state
  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (accept_tx) tx_next = TX_START;
      TX_START: if (tx_tc)     tx_next = TX_DATA;
`ifdef UART_PARITY_EN
      TX_DATA:   if (tx_tc && tx_idx == IDX_LAST) tx_next = TX_PARITY;
      TX_PARITY: if (tx_tc) tx_next = TX_STOP;
`else
      TX_DATA:   if (tx_tc && tx_idx == IDX_LAST) tx_next = TX_STOP;
`endif
      TX_STOP:  if (tx_tc)     tx_next = TX_IDLE;
      default:                 tx_next = TX_IDLE;
    endcase
  end

  // TX line level decoded from state; idle and stop are high
  always_comb begin
    txd = 1'b1;
    case (tx_state)
      TX_START:  txd = 1'b0;
      TX_DATA:   txd = tx_byte[tx_idx];
`ifdef UART_PARITY_EN
      TX_PARITY: txd = ^tx_byte;
`endif
      default:   txd = 1'b1;
    endcase
  end

  // rxd synchroniser plus one history flop for falling-edge detect
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) {rxd_s3, rxd_s2, rxd_s1} <= 3'b111;
    else       {rxd_s3, rxd_s2, rxd_s1} <= {rxd_s2, rxd_s1, rxd};
  end

  assign rx_fall = rxd_s3 && !rxd_s2;
  assign rx_tc   = (rx_cnt == '0);

  // RX state, bit down-counter, bit index and shift register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      rx_state <= RX_IDLE;
      rx_cnt   <= CNT_HALF;
      rx_idx   <= '0;
      rx_shift <= '0;
`ifdef UART_PARITY_EN
      rx_par_err <= 1'b0;
`endif
    end else begin
      rx_state <= rx_next;
      if (rx_state == RX_IDLE) rx_cnt <= CNT_HALF;
      else if (rx_tc)          rx_cnt <= CNT_FULL;
      else                     rx_cnt <= rx_cnt - 1'b1;
      if (rx_state == RX_IDLE)               rx_idx <= '0;
      else if (rx_state == RX_DATA && rx_tc) rx_idx <= rx_idx + 1'b1;
      if (rx_state == RX_DATA && rx_tc) rx_shift <= {rxd_s2, rx_shift[UART_BITS-1:1]};
`ifdef UART_PARITY_EN
      if (rx_state == RX_PARITY && rx_tc) rx_par_err <= rxd_s2 ^ (^rx_shift);
`endif
    end
  end

  // RX next-state; a high line at the start midpoint is a glitch
  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      RX_START: if (rx_tc)   rx_next = rxd_s2 ? RX_IDLE : RX_DATA;
`ifdef UART_PARITY_EN
      RX_DATA:   if (rx_tc && rx_idx == IDX_LAST) rx_next = RX_PARITY;
      RX_PARITY: if (rx_tc) rx_next = RX_STOP;
`else
      RX_DATA:   if (rx_tc && rx_idx == IDX_LAST) rx_next = RX_STOP;
`endif
      RX_STOP:  if (rx_tc)   rx_next = RX_IDLE;
      default:               rx_next = RX_IDLE;
    endcase
  end

  // RX output: write only frames with a valid stop (and parity)
  always_comb begin
    rx_wr = (rx_state == RX_STOP) && rx_tc && rxd_s2;
`ifdef UART_PARITY_EN
    if (rx_par_err) rx_wr = 1'b0;
`endif
  end

  uart_rx_fifo #(.FIFO_AW(FIFO_AW)) u_fifo (
    .clk     (clk),
    .rstn    (rstn),
    .wr_en   (fifo_wr),
    .wr_data (rx_shift),
    .rd_en   (fifo_pop),
    .rd_data (fifo_rd_data),
    .empty   (fifo_empty),
    .full    (),
    .overrun (rx_overrun)
  );
endmodule

// File: tb/tb_uart_responder.sv
// Directed bench for uart_responder with CLKS_PER_BIT=8, FIFO_AW=2.
module tb_uart_responder;
  localparam int CPB = 8;
`ifdef UART_PARITY_EN
  localparam int FRAME_BITS = 11;
`else
  localparam int FRAME_BITS = 10;
`endif

  logic clk, rstn, txd, rxd, rx_overrun;
  uart_responder_if bus();

  uart_responder #(.CLKS_PER_BIT(CPB), .FIFO_AW(2)) dut (
    .clk        (clk),
    .rstn       (rstn),
    .bus        (bus.slave),
    .txd        (txd),
    .rxd        (rxd),
    .rx_overrun (rx_overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int tx_done_cnt = 0;
  int rx_done_cnt = 0;
  int rx_done_cyc = 0;
  logic [7:0] rx_last = '0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock; sample 1ns after the edge and log handshake pulses
  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    if (bus.tx_done) tx_done_cnt++;
    if (bus.rx_done) begin
      rx_done_cnt++;
      rx_done_cyc = cyc;
      rx_last     = bus.r_data;
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_bit,
                            input logic par_flip, output int n0);
    n0  = cyc;
    rxd = 1'b0;
    repeat (CPB) step();
    for (int k = 0; k < 8; k++) begin
      rxd = b[k];
      repeat (CPB) step();
    end
`ifdef UART_PARITY_EN
    rxd = (^b) ^ par_flip;
    repeat (CPB) step();
`endif
    rxd = stop_bit;
    repeat (CPB) step();
    rxd = 1'b1;
    repeat (CPB) step();
  endtask

  task automatic do_read(input string tag, input logic [7:0] exp);
    bus.r_valid = 1'b1;
    step();
    bus.r_valid = 1'b0;
    chk({tag, "_rx_done"}, bus.rx_done, 1'b1);
    chk({tag, "_r_data"}, bus.r_data, exp);
    step();
  endtask

  initial begin
    int n0;
    int cnt0;
    int s;
    logic [10:0] txf;

    rstn        = 1'b0;
    rxd         = 1'b1;
    bus.t_valid = 1'b0;
    bus.r_valid = 1'b0;
    bus.t_data  = '0;
    repeat (2) step();

    chk("rst_ready",   bus.ready,   1'b0);
    chk("rst_tx_done", bus.tx_done, 1'b0);
    chk("rst_rx_done", bus.rx_done, 1'b0);
    chk("rst_r_data",  bus.r_data,  8'h00);
    chk("rst_txd",     txd,         1'b1);
    chk("rst_overrun", rx_overrun,  1'b0);

    rstn = 1'b1;
    step();
    chk("ready_after_rst", bus.ready, 1'b1);

    // Transmit A5 with a simultaneous receive request (transmit wins)
    txf    = '1;
    txf[0] = 1'b0;
    txf[8:1] = 8'hA5;
`ifdef UART_PARITY_EN
    txf[9] = 1'b0;
`endif
    bus.t_valid = 1'b1;
    bus.r_valid = 1'b1;
    bus.t_data  = 8'hA5;
    step();
    bus.t_valid = 1'b0;
    bus.r_valid = 1'b0;
    s = cyc;
    for (int i = 0; i < FRAME_BITS * CPB; i++) begin
      chk("tx_bit", txd, txf[i / CPB]);
      if (i == 40) chk("tx_busy_ready", bus.ready, 1'b0);
      step();
    end
    chk("tx_done_pulse", bus.tx_done, 1'b1);
    chk("tx_done_delay", cyc - s, FRAME_BITS * CPB);
    chk("tx_ready_back", bus.ready, 1'b1);
    repeat (3) step();
    chk("tx_done_once", tx_done_cnt, 1);
    chk("tx_rx_dropped", rx_done_cnt, 0);
    chk("tx_idle_ready", bus.ready, 1'b1);

    // Buffered receive
    send_frame(8'h3C, 1'b1, 1'b0, n0);
    chk("buf_no_early_done", rx_done_cnt, 0);
    bus.r_valid = 1'b1;
    step();
    bus.r_valid = 1'b0;
    chk("buf_rx_done", bus.rx_done, 1'b1);
    chk("buf_r_data",  bus.r_data,  8'h3C);
    chk("buf_ready_low", bus.ready, 1'b0);
    step();
    chk("buf_ready_back", bus.ready, 1'b1);

    // Blocking receive on an empty FIFO
    bus.r_valid = 1'b1;
    step();
    bus.r_valid = 1'b0;
    chk("blk_ready_low", bus.ready, 1'b0);
    repeat (5) step();
    chk("blk_still_wait", bus.ready, 1'b0);
    chk("blk_no_done", rx_done_cnt, 1);
    send_frame(8'h81, 1'b1, 1'b0, n0);
    chk("blk_done_cnt", rx_done_cnt, 2);
    chk("blk_r_data",   rx_last, 8'h81);
    chk("blk_done_cyc", rx_done_cyc, n0 + FRAME_BITS * CPB - 1);
    chk("blk_ready_back", bus.ready, 1'b1);

    // Overrun: five frames into a four-entry FIFO
    chk("ovr_clear", rx_overrun, 1'b0);
    for (int k = 1; k <= 5; k++) send_frame(8'(k), 1'b1, 1'b0, n0);
    chk("ovr_set", rx_overrun, 1'b1);
    do_read("ovr_rd1", 8'h01);
    do_read("ovr_rd2", 8'h02);
    do_read("ovr_rd3", 8'h03);
    do_read("ovr_rd4", 8'h04);

    // Glitch, framing error and (optionally) parity error write nothing
    cnt0 = rx_done_cnt;
    rxd = 1'b0;
    repeat (2) step();
    rxd = 1'b1;
    repeat (16) step();
    send_frame(8'h55, 1'b0, 1'b0, n0);
`ifdef UART_PARITY_EN
    send_frame(8'h66, 1'b1, 1'b1, n0);
`endif
    send_frame(8'h7E, 1'b1, 1'b0, n0);
    chk("err_no_done", rx_done_cnt, cnt0);
    do_read("err_clean", 8'h7E);
    chk("err_overrun_sticky", rx_overrun, 1'b1);

    // Reset in the middle of the data bits
    bus.t_valid = 1'b1;
    bus.t_data  = 8'hC3;
    step();
    bus.t_valid = 1'b0;
    repeat (20) step();
    chk("mid_busy", bus.ready, 1'b0);
    cnt0 = tx_done_cnt;
    rstn = 1'b0;
    #1;
    chk("mid_rst_txd", txd, 1'b1);
    chk("mid_rst_ready", bus.ready, 1'b0);
    chk("mid_rst_overrun", rx_overrun, 1'b0);
    step();
    step();
    rstn = 1'b1;
    step();
    chk("mid_ready_back", bus.ready, 1'b1);
    repeat (100) step();
    chk("mid_no_tx_done", tx_done_cnt, cnt0);
    chk("mid_txd_idle", txd, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
